seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous display
// updates and optional leading-zero blanking.
module seg_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  ga,
  output logic        updated
);

  localparam logic [15:0] RC_LAST = SCAN_DIV - 16'd1;
  localparam logic [1:0]  DI_LAST = 2'd3;
  localparam logic [6:0]  SEG_OFF = 7'h7F;
  localparam logic [3:0]  GA_OFF  = 4'hF;

  logic [15:0] rc_r;
  logic [1:0]  di_r;
  logic [15:0] shadow_r;
  logic [15:0] disp_r;
  logic        pending_r;

  logic        tick_s;
  logic        fb_s;
  logic [3:0]  nib_s;
  logic        blank_s;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'h40;
      4'h1:    hex_decode = 7'h79;
      4'h2:    hex_decode = 7'h24;
      4'h3:    hex_decode = 7'h30;
      4'h4:    hex_decode = 7'h19;
      4'h5:    hex_decode = 7'h12;
      4'h6:    hex_decode = 7'h02;
      4'h7:    hex_decode = 7'h78;
      4'h8:    hex_decode = 7'h00;
      4'h9:    hex_decode = 7'h10;
      4'hA:    hex_decode = 7'h08;
      4'hB:    hex_decode = 7'h03;
      4'hC:    hex_decode = 7'h46;
      4'hD:    hex_decode = 7'h21;
      4'hE:    hex_decode = 7'h06;
      4'hF:    hex_decode = 7'h0E;
      default: hex_decode = SEG_OFF;
    endcase
  endfunction

  // Active-low one-cold digit enable for a digit index.
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    case (idx)
      2'd0:    digit_enable = 4'hE;
      2'd1:    digit_enable = 4'hD;
      2'd2:    digit_enable = 4'hB;
      2'd3:    digit_enable = 4'h7;
      default: digit_enable = GA_OFF;
    endcase
  endfunction

  // Scan timing strobes, current nibble and blanking decision.
  always_comb begin
    tick_s  = (rc_r == RC_LAST);
    fb_s    = tick_s && (di_r == DI_LAST);
    nib_s   = 4'h0;
    blank_s = 1'b0;
    case (di_r)
      2'd0: begin
        nib_s   = disp_r[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = disp_r[7:4];
        blank_s = blank_lz && (disp_r[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s   = disp_r[11:8];
        blank_s = blank_lz && (disp_r[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s   = disp_r[15:12];
        blank_s = blank_lz && (disp_r[15:12] == 4'h0);
      end
      default: begin
        nib_s   = 4'h0;
        blank_s = 1'b0;
      end
    endcase
  end

  // Refresh counter and digit index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc_r <= 16'd0;
      di_r <= 2'd0;
    end else if (tick_s) begin
      rc_r <= 16'd0;
      di_r <= di_r + 2'd1;
    end else begin
      rc_r <= rc_r + 16'd1;
      di_r <= di_r;
    end
  end

  // Shadow capture; disp only changes on a frame boundary so a frame never mixes values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_r  <= 16'h0000;
      disp_r    <= 16'h0000;
      pending_r <= 1'b0;
      updated   <= 1'b0;
    end else if (fb_s && load) begin
      shadow_r  <= data_in;
      disp_r    <= data_in;
      pending_r <= 1'b0;
      updated   <= 1'b1;
    end else if (fb_s && pending_r) begin
      shadow_r  <= shadow_r;
      disp_r    <= shadow_r;
      pending_r <= 1'b0;
      updated   <= 1'b1;
    end else if (load) begin
      shadow_r  <= data_in;
      disp_r    <= disp_r;
      pending_r <= 1'b1;
      updated   <= 1'b0;
    end else begin
      shadow_r  <= shadow_r;
      disp_r    <= disp_r;
      pending_r <= pending_r;
      updated   <= 1'b0;
    end
  end

  // Registered segment and digit drive, one cycle behind rc/di.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      ga  <= GA_OFF;
    end else if (blank_s) begin
      seg <= SEG_OFF;
      ga  <= GA_OFF;
    end else begin
      seg <= hex_decode(nib_s);
      ga  <= digit_enable(di_r);
    end
  end

endmodule
